// File: rtl/hdlc_deframer.sv
// HDLC-style receive deframer: removes flags and byte stuffing, checks FCS-16,
// and emits payload bytes with sop/eop markers and a per-packet verdict.
module hdlc_deframer #(
  parameter int unsigned MAX_LEN    = 256,
  parameter bit          FCS_ENABLE = 1'b1
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_strobe,
  output logic [7:0] out_data,
  output logic       out_strobe,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_good,
  output logic [7:0] err_count
);
  localparam int unsigned     CntW    = $clog2(MAX_LEN + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_LEN);
  localparam logic [7:0]      Flag    = 8'h7E;
  localparam logic [7:0]      Esc     = 8'h7D;
  localparam logic [15:0]     CrcInit = 16'hFFFF;
  localparam logic [15:0]     CrcGood = 16'hF0B8;

  typedef enum logic [2:0] {StHunt, StIdle, StData, StEsc, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [15:0]     crc_q, crc_d;
  logic [1:0]      acc_q, acc_d;  // accepted bytes this frame, saturating at 3
  logic [7:0]      dly_old_q, dly_old_d, dly_new_q, dly_new_d;
  logic [CntW-1:0] pay_q, pay_d;
  logic [7:0]      data_q, data_d;
  logic            strobe_q, strobe_d, sop_q, sop_d, eop_q, eop_d, good_q, good_d;
  logic [7:0]      err_q, err_d;
  logic            accept, close, abort, flag_seen, err_inc, emit_now;
  logic [7:0]      acc_byte, emit_byte;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    acc_d     = acc_q;
    dly_old_d = dly_old_q;
    dly_new_d = dly_new_q;
    pay_d     = pay_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    sop_d     = sop_q;
    eop_d     = 1'b0;
    good_d    = good_q;
    err_d     = err_q;
    accept    = 1'b0;
    close     = 1'b0;
    abort     = 1'b0;
    flag_seen = 1'b0;
    err_inc   = 1'b0;
    emit_now  = 1'b0;
    acc_byte  = in_data;
    emit_byte = in_data;

    if (in_strobe) begin
      flag_seen = (in_data == Flag);
      unique case (state_q)
        StHunt, StDiscard: begin
          if (flag_seen) state_d = StIdle;
        end
        StIdle, StData: begin
          if (flag_seen) begin
            close   = (state_q == StData);
            state_d = StIdle;
          end else if (in_data == Esc) begin
            state_d = StEsc;
          end else begin
            accept  = 1'b1;
            state_d = StData;
          end
        end
        StEsc: begin
          if (flag_seen) begin
            abort   = 1'b1;
            state_d = StIdle;
          end else begin
            accept   = 1'b1;
            acc_byte = in_data ^ 8'h20;
            state_d  = StData;
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (accept) begin
      crc_d     = crc_upd(crc_q, acc_byte);
      if (acc_q != 2'd3) acc_d = acc_q + 2'd1;
      dly_old_d = dly_new_q;
      dly_new_d = acc_byte;
      // With FCS the delay line releases a byte only once two newer ones are held.
      emit_now  = FCS_ENABLE ? (acc_q >= 2'd2) : 1'b1;
      emit_byte = FCS_ENABLE ? dly_old_q : acc_byte;
      if (emit_now) begin
        if (pay_q == MaxCnt) begin
          eop_d   = 1'b1;
          good_d  = 1'b0;
          err_inc = 1'b1;
          state_d = StDiscard;
        end else begin
          strobe_d = 1'b1;
          data_d   = emit_byte;
          sop_d    = (pay_q == '0);
          pay_d    = pay_q + CntW'(1);
        end
      end
    end

    if (close) begin
      if (FCS_ENABLE ? (acc_q < 2'd3) : (acc_q == 2'd0)) begin
        err_inc = 1'b1;
      end else begin
        eop_d   = 1'b1;
        good_d  = FCS_ENABLE ? (crc_q == CrcGood) : 1'b1;
        err_inc = FCS_ENABLE && (crc_q != CrcGood);
      end
    end

    if (abort) begin
      if (pay_q != '0) begin
        eop_d  = 1'b1;
        good_d = 1'b0;
      end
      err_inc = 1'b1;
    end

    if (flag_seen) begin
      crc_d = CrcInit;
      acc_d = 2'd0;
      pay_d = '0;
    end

    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= StHunt;
      crc_q     <= CrcInit;
      acc_q     <= 2'd0;
      dly_old_q <= 8'h00;
      dly_new_q <= 8'h00;
      pay_q     <= '0;
      data_q    <= 8'h00;
      strobe_q  <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      good_q    <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      acc_q     <= acc_d;
      dly_old_q <= dly_old_d;
      dly_new_q <= dly_new_d;
      pay_q     <= pay_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      good_q    <= good_d;
      err_q     <= err_d;
    end
  end

  assign out_data   = data_q;
  assign out_strobe = strobe_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign out_good   = good_q;
  assign err_count  = err_q;

endmodule
